// File: rtl/inst_fetch_port_pkg.sv
// Shared types and constants for the instruction fetch port: FSM encoding,
// byte-count widths and the per-instruction byte count.
package inst_fetch_port_pkg;

  typedef enum logic {
    FetchIdle = 1'b0,
    FetchBusy = 1'b1
  } fetch_state_e;

  localparam int unsigned CntWidth     = 3;
  localparam int unsigned RcvWidth     = 2;
  localparam int unsigned BytesPerInst = 4;
  localparam int unsigned LaneBits     = 8 * (BytesPerInst - 1);

  localparam logic [CntWidth-1:0] IssueDone = 3'd4;
  localparam logic [RcvWidth-1:0] LastLane  = 2'd3;

  function automatic logic [CntWidth-1:0] cnt_inc(input logic [CntWidth-1:0] cnt);
    return cnt + 3'd1;
  endfunction

endpackage

// File: rtl/inst_fetch_port_byte_assembler.sv
// Collects returning bytes into little-endian lanes; flags the cycle in which
// the final lane is on the bus so the top level can capture the full word.
module fetch_byte_assembler
  import inst_fetch_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  pend_i,
  input  logic [7:0]            byte_i,
  output logic                  complete_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [LaneBits-1:0] lanes_q, lanes_d;
  logic [RcvWidth-1:0] rcv_cnt_q, rcv_cnt_d;

  // Lane 3 is never stored: it is forwarded straight into the captured word.
  assign complete_o = pend_i && !clear_i && (rcv_cnt_q == LastLane);
  assign word_o     = {byte_i, lanes_q};

  always_comb begin
    lanes_d   = lanes_q;
    rcv_cnt_d = rcv_cnt_q;
    if (clear_i) begin
      rcv_cnt_d = 2'd0;
    end else if (pend_i) begin
      case (rcv_cnt_q)
        2'd0:    lanes_d[7:0]   = byte_i;
        2'd1:    lanes_d[15:8]  = byte_i;
        2'd2:    lanes_d[23:16] = byte_i;
        default: lanes_d        = lanes_q;
      endcase
      rcv_cnt_d = rcv_cnt_q + 2'd1;
    end else begin
      rcv_cnt_d = rcv_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q   <= {LaneBits{1'b0}};
      rcv_cnt_q <= 2'd0;
    end else begin
      lanes_q   <= lanes_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

endmodule

// File: rtl/inst_fetch_port.sv
// Instruction-memory port: fetches a word as four byte reads over an
// arbitrated 1-cycle bus and keeps the last word in a one-entry buffer.
module inst_fetch_port
  import inst_fetch_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  input  logic                  mem_grant_i,
  input  logic [7:0]            mem_data_i
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fa_q, fa_d;
  logic [CntWidth-1:0]   iss_cnt_q, iss_cnt_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;

  logic                  hit_s;
  logic                  asm_clear_s;
  logic                  asm_complete_s;
  logic [DATA_WIDTH-1:0] asm_word_s;

  // busy_o looks only at addr_i and registered state, so IF cannot close a loop through it.
  assign hit_s       = buf_valid_q && (buf_addr_q == addr_i);
  assign busy_o      = (state_q != FetchIdle) || !hit_s;
  assign asm_clear_s = (state_q == FetchIdle) || flush_i;
  assign data_o      = data_q;
  assign done_o      = done_q;

  fetch_byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (asm_clear_s),
    .pend_i     (pend_q),
    .byte_i     (mem_data_i),
    .complete_o (asm_complete_s),
    .word_o     (asm_word_s)
  );

  always_comb begin
    mem_re_o   = 1'b0;
    mem_addr_o = {ADDR_WIDTH{1'b0}};
    if (state_q == FetchBusy) begin
      mem_re_o   = (iss_cnt_q < IssueDone);
      mem_addr_o = fa_q + ADDR_WIDTH'(iss_cnt_q);
    end else begin
      mem_re_o   = 1'b0;
      mem_addr_o = {ADDR_WIDTH{1'b0}};
    end
  end

  always_comb begin
    state_d     = state_q;
    fa_d        = fa_q;
    iss_cnt_d   = iss_cnt_q;
    pend_d      = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_valid_d = buf_valid_q;
    data_d      = data_q;
    done_d      = 1'b0;
    case (state_q)
      FetchIdle: begin
        if (!hit_s) begin
          fa_d      = addr_i;
          iss_cnt_d = 3'd0;
          state_d   = FetchBusy;
        end else begin
          state_d   = FetchIdle;
        end
      end
      FetchBusy: begin
        if (flush_i) begin
          // Flush beats a same-cycle lane-3 capture; the buffer keeps its old word.
          state_d   = FetchIdle;
          iss_cnt_d = 3'd0;
          pend_d    = 1'b0;
        end else begin
          if (mem_re_o && mem_grant_i) begin
            iss_cnt_d = cnt_inc(iss_cnt_q);
            pend_d    = 1'b1;
          end else begin
            pend_d    = 1'b0;
          end
          if (asm_complete_s) begin
            data_d      = asm_word_s;
            buf_addr_d  = fa_q;
            buf_valid_d = 1'b1;
            done_d      = 1'b1;
            state_d     = FetchIdle;
          end else begin
            state_d     = FetchBusy;
          end
        end
      end
      default: begin
        state_d = FetchIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FetchIdle;
      fa_q        <= {ADDR_WIDTH{1'b0}};
      iss_cnt_q   <= 3'd0;
      pend_q      <= 1'b0;
      buf_addr_q  <= {ADDR_WIDTH{1'b0}};
      buf_valid_q <= 1'b0;
      data_q      <= {DATA_WIDTH{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fa_q        <= fa_d;
      iss_cnt_q   <= iss_cnt_d;
      pend_q      <= pend_d;
      buf_addr_q  <= buf_addr_d;
      buf_valid_q <= buf_valid_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Self-checking bench for inst_fetch_port: cycle table for cold fetch + hits,
// hand sequences for stalls, flush, wrap-around and async reset.
module tb_inst_fetch_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic        flush_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_grant_i;
  logic [7:0]  mem_data_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic        grant;
    logic        flush;
    logic        busy;
    logic        done;
    logic        re;
    logic [31:0] maddr;
  } vec_t;
  vec_t vecs[17];

  logic [7:0] staged = 8'hEE;

  inst_fetch_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (addr_i),
    .flush_i     (flush_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_addr_o  (mem_addr_o),
    .mem_re_o    (mem_re_o),
    .mem_grant_i (mem_grant_i),
    .mem_data_i  (mem_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0000_0001: return 8'h05;
      32'h0000_0002: return 8'h10;
      32'h0000_0003: return 8'h00;
      default:       return a[7:0] ^ 8'h5A ^ a[31:24];
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem_byte(a3), mem_byte(a2), mem_byte(a1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic [31:0] a, input logic g, input logic f);
    @(posedge clk);
    #1;
    addr_i      = a;
    mem_grant_i = g;
    flush_i     = f;
    @(negedge clk);
  endtask

  task automatic wait_done(input logic [31:0] a, input int max_cycles);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      cyc(a, 1'b1, 1'b0);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_done", {31'd0, got}, 32'd1);
  endtask

  // Memory model: a granted request returns its byte one cycle later.
  always @(negedge clk) begin
    mem_data_i = staged;
    staged     = (mem_re_o && mem_grant_i) ? mem_byte(mem_addr_o) : 8'hEE;
  end

  // Scoreboard: every completion pops the oldest expected word.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending fetch at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", data_o, e.word);
      end
    end
  end

  initial begin
    logic [31:0] wrap_seq [4];

    rst         = 1'b1;
    addr_i      = 32'h0;
    flush_i     = 1'b0;
    mem_grant_i = 1'b1;
    mem_data_i  = 8'h00;

    // Cold fetch T0..T6, then ten hit cycles
    vecs[0] = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1};
    vecs[3] = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2};
    vecs[4] = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3};
    vecs[5] = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    for (int i = 7; i < 17; i++) vecs[i] = '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd1);
    chk("rst_data", data_o, 32'h0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_re", {31'd0, mem_re_o}, 32'd0);
    chk("rst_maddr", mem_addr_o, 32'h0);

    sb.push_back('{32'h0, exp_word(32'h0)});
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      rst         = 1'b0;
      addr_i      = vecs[i].addr;
      mem_grant_i = vecs[i].grant;
      flush_i     = vecs[i].flush;
      @(negedge clk);
      chk($sformatf("cold_busy[%0d]", i), {31'd0, busy_o}, {31'd0, vecs[i].busy});
      chk($sformatf("cold_done[%0d]", i), {31'd0, done_o}, {31'd0, vecs[i].done});
      chk($sformatf("cold_re[%0d]", i), {31'd0, mem_re_o}, {31'd0, vecs[i].re});
      if (vecs[i].re) chk($sformatf("cold_maddr[%0d]", i), mem_addr_o, vecs[i].maddr);
    end
    chk("cold_word", data_o, 32'h0010_0513);

    // Grant stalls in T2/T3: done lands at T8
    sb.push_back('{32'h4, exp_word(32'h4)});
    cyc(32'h4, 1'b1, 1'b0);
    cyc(32'h4, 1'b1, 1'b0);
    chk("stall_t1_maddr", mem_addr_o, 32'h4);
    cyc(32'h4, 1'b0, 1'b0);
    chk("stall_t2_maddr", mem_addr_o, 32'h5);
    chk("stall_t2_re", {31'd0, mem_re_o}, 32'd1);
    cyc(32'h4, 1'b0, 1'b0);
    chk("stall_t3_maddr", mem_addr_o, 32'h5);
    for (int t = 4; t <= 7; t++) begin
      cyc(32'h4, 1'b1, 1'b0);
      chk($sformatf("stall_t%0d_done", t), {31'd0, done_o}, 32'd0);
    end
    cyc(32'h4, 1'b1, 1'b0);
    chk("stall_t8_done", {31'd0, done_o}, 32'd1);
    chk("stall_t8_busy", {31'd0, busy_o}, 32'd0);
    chk("stall_t8_data", data_o, exp_word(32'h4));

    // Flush on the lane-3 capture cycle
    for (int t = 0; t <= 4; t++) cyc(32'h8, 1'b1, 1'b0);
    cyc(32'h8, 1'b1, 1'b1);
    cyc(32'h8, 1'b1, 1'b0);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    chk("flush_keep", data_o, exp_word(32'h4));
    chk("flush_busy", {31'd0, busy_o}, 32'd1);
    sb.push_back('{32'h8, exp_word(32'h8)});
    cyc(32'h8, 1'b1, 1'b0);
    chk("refetch_re", {31'd0, mem_re_o}, 32'd1);
    chk("refetch_maddr", mem_addr_o, 32'h8);
    wait_done(32'h8, 12);
    chk("refetch_data", data_o, exp_word(32'h8));

    // Wrap-around
    wrap_seq[0] = 32'hFFFF_FFFE;
    wrap_seq[1] = 32'hFFFF_FFFF;
    wrap_seq[2] = 32'h0000_0000;
    wrap_seq[3] = 32'h0000_0001;
    sb.push_back('{32'hFFFF_FFFE, exp_word(32'hFFFF_FFFE)});
    cyc(32'hFFFF_FFFE, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(32'hFFFF_FFFE, 1'b1, 1'b0);
      chk($sformatf("wrap_maddr[%0d]", k), mem_addr_o, wrap_seq[k]);
    end
    wait_done(32'hFFFF_FFFE, 6);
    chk("wrap_data", data_o, exp_word(32'hFFFF_FFFE));

    // Async reset during T3 of a fetch
    for (int t = 0; t <= 3; t++) cyc(32'h10, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 32'd1);
    chk("arst_data", data_o, 32'h0);
    chk("arst_done", {31'd0, done_o}, 32'd0);
    chk("arst_re", {31'd0, mem_re_o}, 32'd0);
    chk("arst_maddr", mem_addr_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_t4_data", data_o, 32'h0);
    chk("arst_t4_done", {31'd0, done_o}, 32'd0);
    sb.push_back('{32'h10, exp_word(32'h10)});
    cyc(32'h10, 1'b1, 1'b0);
    chk("arst_t5_data", data_o, 32'h0);
    chk("arst_t5_maddr", mem_addr_o, 32'h10);
    wait_done(32'h10, 10);
    chk("arst_refetch", data_o, exp_word(32'h10));

    repeat (2) cyc(32'h10, 1'b1, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
